// File: rtl/cpu_adr_seq.sv
// Bus/addressing sequencer for the 6502-style core: reset-vector fetch, opcode and operand
// fetch, effective-address formation (IMPL/IMM/ZP/ZPI/ABS/ABSI) and the data memory cycle.
module cpu_adr_seq #(
  parameter int ADR_W        = 16,
  parameter int DATA_W       = 8,
  parameter int VECTOR_FETCH = 1,
  parameter     RESET_VECTOR = 16'hFFFC,
  parameter     RESET_PC     = 16'h8000,
  parameter int PAGE_PENALTY = 1
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              rdy,
  output logic [ADR_W-1:0]  adr_bus,
  output logic              RW,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  input  logic [2:0]        mode,
  input  logic              idx_sel,
  input  logic [DATA_W-1:0] idx_x,
  input  logic [DATA_W-1:0] idx_y,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] opcode,
  output logic              opcode_valid,
  output logic [DATA_W-1:0] operand,
  output logic              operand_valid,
  output logic [ADR_W-1:0]  ea,
  output logic [ADR_W-1:0]  pc,
  output logic              mode_err,
  output logic [2:0]        state_dbg
);

  // rdy handshake: rdy=0 freezes every register and holds the bus (a pending write keeps
  // RW=0). Strobes are registered and qualified by rdy, so each event shows for exactly
  // one rdy-high cycle. Reset wins over rdy.
  typedef enum logic [2:0] {
    S_VEC_LO = 3'd0,
    S_VEC_HI = 3'd1,
    S_FETCH  = 3'd2,
    S_OP1    = 3'd3,
    S_OP2    = 3'd4,
    S_FIX    = 3'd5,
    S_MEM    = 3'd6
  } state_t;

  localparam state_t           RST_STATE  = (VECTOR_FETCH != 0) ? S_VEC_LO : S_FETCH;
  localparam logic [ADR_W-1:0] VEC_LO_ADR = ADR_W'(RESET_VECTOR);
  localparam logic [ADR_W-1:0] VEC_HI_ADR = VEC_LO_ADR + ADR_W'(1);
  localparam logic [ADR_W-1:0] PC_INIT    = ADR_W'(RESET_PC);

  state_t            state_q, state_d;
  logic [ADR_W-1:0]  pc_q, pc_d;
  logic [ADR_W-1:0]  ea_q, ea_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic              carry_q, carry_d;
  logic [DATA_W-1:0] opcode_q, opcode_d;
  logic [DATA_W-1:0] operand_q, operand_d;
  logic              opv_q, opv_d;
  logic              operv_q, operv_d;
  logic              merr_q, merr_d;

  logic [DATA_W-1:0] idx_val;
  logic [DATA_W:0]   idx_sum;

  assign idx_val = idx_sel ? idx_y : idx_x;
  assign idx_sum = {1'b0, data_in} + {1'b0, idx_val};

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q   <= RST_STATE;
      pc_q      <= PC_INIT;
      ea_q      <= '0;
      lo_q      <= '0;
      carry_q   <= 1'b0;
      opcode_q  <= '0;
      operand_q <= '0;
      opv_q     <= 1'b0;
      operv_q   <= 1'b0;
      merr_q    <= 1'b0;
    end else if (rdy) begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ea_q      <= ea_d;
      lo_q      <= lo_d;
      carry_q   <= carry_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
      opv_q     <= opv_d;
      operv_q   <= operv_d;
      merr_q    <= merr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ea_d      = ea_q;
    lo_d      = lo_q;
    carry_d   = carry_q;
    opcode_d  = opcode_q;
    operand_d = operand_q;
    opv_d     = 1'b0;
    operv_d   = 1'b0;
    merr_d    = 1'b0;
    case (state_q)
      S_VEC_LO: begin
        lo_d    = data_in;
        state_d = S_VEC_HI;
      end
      S_VEC_HI: begin
        pc_d    = {data_in, lo_q};
        state_d = S_FETCH;
      end
      S_FETCH: begin
        opcode_d = data_in;
        pc_d     = pc_q + ADR_W'(1);
        opv_d    = 1'b1;
        state_d  = S_OP1;
      end
      S_OP1: begin
        case (mode)
          3'd0: begin
            operv_d = 1'b1;
            state_d = S_FETCH;
          end
          3'd1: begin
            operand_d = data_in;
            pc_d      = pc_q + ADR_W'(1);
            operv_d   = 1'b1;
            state_d   = S_FETCH;
          end
          3'd2: begin
            ea_d    = {{DATA_W{1'b0}}, data_in};
            pc_d    = pc_q + ADR_W'(1);
            state_d = S_MEM;
          end
          3'd3: begin
            // Zero-page indexing wraps inside page 0; the carry is dropped.
            ea_d    = {{DATA_W{1'b0}}, idx_sum[DATA_W-1:0]};
            pc_d    = pc_q + ADR_W'(1);
            state_d = S_MEM;
          end
          3'd4: begin
            lo_d    = data_in;
            carry_d = 1'b0;
            pc_d    = pc_q + ADR_W'(1);
            state_d = S_OP2;
          end
          3'd5: begin
            lo_d    = idx_sum[DATA_W-1:0];
            carry_d = idx_sum[DATA_W];
            pc_d    = pc_q + ADR_W'(1);
            state_d = S_OP2;
          end
          default: begin
            operv_d = 1'b1;
            merr_d  = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_OP2: begin
        pc_d = pc_q + ADR_W'(1);
        if (carry_q && (PAGE_PENALTY != 0)) begin
          // Uncorrected address first; FIX repairs the high byte one cycle later.
          ea_d    = {data_in, lo_q};
          state_d = S_FIX;
        end else begin
          ea_d    = {data_in + DATA_W'(carry_q), lo_q};
          state_d = S_MEM;
        end
      end
      S_FIX: begin
        ea_d    = {ea_q[ADR_W-1:DATA_W] + DATA_W'(1), ea_q[DATA_W-1:0]};
        state_d = S_MEM;
      end
      S_MEM: begin
        if (!wr_req) operand_d = data_in;
        operv_d = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = RST_STATE;
    endcase
  end

  always_comb begin
    adr_bus  = pc_q;
    RW       = 1'b1;
    data_out = '0;
    case (state_q)
      S_VEC_LO: adr_bus = VEC_LO_ADR;
      S_VEC_HI: adr_bus = VEC_HI_ADR;
      S_FIX:    adr_bus = ea_q;
      S_MEM: begin
        adr_bus  = ea_q;
        RW       = ~wr_req;
        data_out = wr_data;
      end
      default:  adr_bus = pc_q;
    endcase
  end

  assign opcode        = opcode_q;
  assign operand       = operand_q;
  assign ea            = ea_q;
  assign pc            = pc_q;
  assign opcode_valid  = opv_q & rdy;
  assign operand_valid = operv_q & rdy;
  assign mode_err      = merr_q & rdy;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_cpu_adr_seq.sv
// Bench for cpu_adr_seq: two instances (penalty+vector fetch, and no-penalty+fixed PC),
// instruction-level reference model predicting bus trace, operand, ea, pc and writes.
module tb_cpu_adr_seq;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        n_reset_a, n_reset_b, rdy, sel;
  logic [2:0]  mode;
  logic        idx_sel, wr_req;
  logic [7:0]  idx_x, idx_y, wr_data;
  logic [7:0]  mem [0:65535];

  logic [15:0] adr_a, ea_a, pc_a, adr_b, ea_b, pc_b;
  logic        rw_a, opv_a, operv_a, merr_a, rw_b, opv_b, operv_b, merr_b;
  logic [7:0]  din_a, dout_a, opc_a, oper_a, din_b, dout_b, opc_b, oper_b;
  logic [2:0]  st_a, st_b;

  assign din_a = mem[adr_a];
  assign din_b = mem[adr_b];

  cpu_adr_seq #(.VECTOR_FETCH(1), .RESET_VECTOR(16'hFFFC), .RESET_PC(16'h8000), .PAGE_PENALTY(1)) u_dut_a (
    .clk(clk), .n_reset(n_reset_a), .rdy(rdy), .adr_bus(adr_a), .RW(rw_a), .data_in(din_a),
    .data_out(dout_a), .mode(mode), .idx_sel(idx_sel), .idx_x(idx_x), .idx_y(idx_y),
    .wr_req(wr_req), .wr_data(wr_data), .opcode(opc_a), .opcode_valid(opv_a), .operand(oper_a),
    .operand_valid(operv_a), .ea(ea_a), .pc(pc_a), .mode_err(merr_a), .state_dbg(st_a));

  cpu_adr_seq #(.VECTOR_FETCH(0), .RESET_VECTOR(16'hFFFC), .RESET_PC(16'h8000), .PAGE_PENALTY(0)) u_dut_b (
    .clk(clk), .n_reset(n_reset_b), .rdy(rdy), .adr_bus(adr_b), .RW(rw_b), .data_in(din_b),
    .data_out(dout_b), .mode(mode), .idx_sel(idx_sel), .idx_x(idx_x), .idx_y(idx_y),
    .wr_req(wr_req), .wr_data(wr_data), .opcode(opc_b), .opcode_valid(opv_b), .operand(oper_b),
    .operand_valid(operv_b), .ea(ea_b), .pc(pc_b), .mode_err(merr_b), .state_dbg(st_b));

  logic [15:0] o_adr, o_ea, o_pc;
  logic        o_rw, o_opv, o_operv, o_merr;
  logic [7:0]  o_dout, o_opc, o_oper;
  assign o_adr   = sel ? adr_b   : adr_a;
  assign o_ea    = sel ? ea_b    : ea_a;
  assign o_pc    = sel ? pc_b    : pc_a;
  assign o_rw    = sel ? rw_b    : rw_a;
  assign o_opv   = sel ? opv_b   : opv_a;
  assign o_operv = sel ? operv_b : operv_a;
  assign o_merr  = sel ? merr_b  : merr_a;
  assign o_dout  = sel ? dout_b  : dout_a;
  assign o_opc   = sel ? opc_b   : opc_a;
  assign o_oper  = sel ? oper_b  : oper_a;

  int          vecs = 0;
  int          errs = 0;
  int          wcnt = 0;
  int          wc;
  logic [15:0] t16;

  // Reference model state, tracked at instruction granularity.
  logic [15:0] m_pc, m_ea;
  logic [7:0]  m_operand;
  logic        pend;
  logic [7:0]  pend_operand;
  logic [15:0] pend_ea, pend_pc;
  logic        pend_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; the memory model commits a write only on a non-reset, rdy-high write cycle.
  task automatic tick();
    logic       do_wr;
    logic [15:0] wa;
    logic [7:0]  wd;
    do_wr = (sel ? n_reset_b : n_reset_a) && rdy && !o_rw;
    wa = o_adr;
    wd = o_dout;
    @(posedge clk);
    if (do_wr) begin
      mem[wa] = wd;
      wcnt++;
    end
    #1;
  endtask

  // Leaves the bench at the rdy-high sample point of the cycle, before its clock edge.
  task automatic bus_cycle(input logic [15:0] adr_e, input logic rw_e, input int nstall, input logic [7:0] wd);
    for (int s = 0; s < nstall; s++) begin
      rdy = 1'b0;
      #1;
      chk("stall_adr", o_adr, adr_e);
      chk("stall_rw", o_rw, rw_e);
      chk("stall_strobes", {o_opv, o_operv, o_merr}, 3'b000);
      tick();
    end
    rdy = 1'b1;
    #1;
    chk("adr", o_adr, adr_e);
    chk("rw", o_rw, rw_e);
    if (!rw_e) chk("data_out", o_dout, wd);
  endtask

  task automatic check_pending();
    chk("operand_valid", o_operv, 1'b1);
    chk("operand", o_oper, pend_operand);
    chk("ea", o_ea, pend_ea);
    chk("pc", o_pc, pend_pc);
    chk("mode_err", o_merr, pend_err);
    pend = 1'b0;
  endtask

  task automatic reset_dut(input logic which, input logic [15:0] vec, input int stalls);
    n_reset_a = 1'b0;
    n_reset_b = 1'b0;
    sel = which;
    rdy = 1'b0;
    tick();
    rdy = 1'b1;
    #1;
    chk("rst_adr", o_adr, which ? 16'h8000 : 16'hFFFC);
    chk("rst_rw", o_rw, 1'b1);
    chk("rst_opcode", o_opc, 8'h00);
    chk("rst_operand", o_oper, 8'h00);
    chk("rst_ea", o_ea, 16'h0000);
    chk("rst_strobes", {o_opv, o_operv, o_merr}, 3'b000);
    if (which) chk("rst_pc", o_pc, 16'h8000);
    if (which) n_reset_b = 1'b1;
    else n_reset_a = 1'b1;
    pend = 1'b0;
    m_ea = 16'h0000;
    m_operand = 8'h00;
    if (!which) begin
      mem[16'hFFFC] = vec[7:0];
      mem[16'hFFFD] = vec[15:8];
      bus_cycle(16'hFFFC, 1'b1, stalls, 8'h00);
      tick();
      bus_cycle(16'hFFFD, 1'b1, stalls, 8'h00);
      tick();
      m_pc = vec;
    end else begin
      m_pc = 16'h8000;
    end
  endtask

  // mem_stall >= 0: exactly that many rdy-low cycles in the memory cycle, none elsewhere.
  // mem_stall < 0: random stalls on any cycle.
  task automatic run_instr(input logic [2:0] m, input logic isel, input logic [7:0] ix, input logic [7:0] iy,
                           input logic wr, input logic [7:0] wd, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input int mem_stall);
    logic [15:0] exp_q[$];
    logic [15:0] p1, p2, p3, ea_n, npc;
    logic [7:0]  iv;
    logic        memop, last_wr, rw_e;
    int          sumi, nst, wc0;
    mode = m; idx_sel = isel; idx_x = ix; idx_y = iy; wr_req = wr; wr_data = wd;
    p1 = m_pc + 16'd1;
    p2 = m_pc + 16'd2;
    p3 = m_pc + 16'd3;
    mem[m_pc] = b0;
    mem[p1] = b1;
    mem[p2] = b2;
    iv = isel ? iy : ix;
    memop = 1'b0;
    ea_n = m_ea;
    npc = p1;
    exp_q.push_back(m_pc);
    exp_q.push_back(p1);
    case (m)
      3'd1: begin npc = p2; m_operand = b1; end
      3'd2: begin npc = p2; ea_n = {8'h00, b1}; memop = 1'b1; end
      3'd3: begin npc = p2; ea_n = 16'((int'(b1) + int'(iv)) % 256); memop = 1'b1; end
      3'd4: begin
        npc = p3; exp_q.push_back(p2);
        ea_n = 16'(int'(b2) * 256 + int'(b1)); memop = 1'b1;
      end
      3'd5: begin
        npc = p3; exp_q.push_back(p2);
        sumi = int'(b1) + int'(iv);
        ea_n = 16'((int'(b2) * 256 + sumi) % 65536);
        if (!sel && sumi > 255) exp_q.push_back(16'(int'(b2) * 256 + sumi % 256));
        memop = 1'b1;
      end
      default: npc = p1;
    endcase
    if (memop) begin
      exp_q.push_back(ea_n);
      if (!wr) m_operand = mem[ea_n];
    end
    last_wr = memop && wr;
    wc0 = wcnt;
    for (int k = 0; k < exp_q.size(); k++) begin
      rw_e = !(last_wr && k == exp_q.size() - 1);
      if (mem_stall >= 0) nst = (memop && k == exp_q.size() - 1) ? mem_stall : 0;
      else nst = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      bus_cycle(exp_q[k], rw_e, nst, wd);
      if (k == 0) begin
        if (pend) check_pending();
        else chk("operand_valid_idle", o_operv, 1'b0);
      end else begin
        chk("operand_valid_early", o_operv, 1'b0);
        chk("mode_err_early", o_merr, 1'b0);
      end
      if (k == 1) begin
        chk("opcode_valid", o_opv, 1'b1);
        chk("opcode", o_opc, b0);
      end else begin
        chk("opcode_valid_idle", o_opv, 1'b0);
      end
      tick();
    end
    if (last_wr) chk("store_mem", mem[ea_n], wd);
    chk("write_count", wcnt, wc0 + (last_wr ? 1 : 0));
    m_pc = npc;
    m_ea = ea_n;
    pend = 1'b1;
    pend_operand = m_operand;
    pend_ea = ea_n;
    pend_pc = npc;
    pend_err = (m > 3'd5);
  endtask

  task automatic run_random(input int n);
    for (int i = 0; i < n; i++)
      run_instr(3'($urandom_range(0, 7)), 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
                8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), -1);
  endtask

  task automatic drain();
    bus_cycle(m_pc, 1'b1, 0, 8'h00);
    if (pend) check_pending();
    tick();
  endtask

  initial begin
    n_reset_a = 1'b0; n_reset_b = 1'b0; rdy = 1'b0; sel = 1'b0;
    mode = 3'd0; idx_sel = 1'b0; idx_x = 8'h00; idx_y = 8'h00; wr_req = 1'b0; wr_data = 8'h00;
    pend = 1'b0; m_pc = 16'h0000; m_ea = 16'h0000; m_operand = 8'h00;
    pend_operand = 8'h00; pend_ea = 16'h0000; pend_pc = 16'h0000; pend_err = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    tick();
    tick();

    // Instance A: vector fetch, page-cross penalty.
    reset_dut(1'b0, 16'hC000, 0);
    run_instr(3'd1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'hA9, 8'h42, 8'h00, 0);
    mem[16'h0010] = 8'h77;
    run_instr(3'd3, 1'b0, 8'hF0, 8'h00, 1'b0, 8'h00, 8'hB5, 8'h20, 8'h00, 0);
    run_instr(3'd5, 1'b1, 8'h00, 8'h01, 1'b0, 8'h00, 8'hB9, 8'hFF, 8'h12, 0);
    run_instr(3'd4, 1'b0, 8'h00, 8'h00, 1'b1, 8'h5A, 8'h8D, 8'h00, 8'h20, 3);
    run_instr(3'd7, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'hFF, 8'h00, 8'h00, 0);
    run_instr(3'd0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'hEA, 8'h00, 8'h00, 0);
    run_instr(3'd6, 1'b1, 8'h00, 8'h00, 1'b1, 8'h33, 8'h02, 8'h00, 8'h00, 1);
    run_random(120);

    // Reset lands while a stalled store sits in its memory cycle.
    mode = 3'd4; idx_sel = 1'b0; wr_req = 1'b1; wr_data = 8'hA5;
    mem[16'h3000] = 8'h11;
    t16 = m_pc;
    mem[t16] = 8'h8D;
    bus_cycle(t16, 1'b1, 0, 8'h00);
    if (pend) check_pending();
    tick();
    t16 = t16 + 16'd1;
    mem[t16] = 8'h00;
    bus_cycle(t16, 1'b1, 0, 8'h00);
    tick();
    t16 = t16 + 16'd1;
    mem[t16] = 8'h30;
    bus_cycle(t16, 1'b1, 0, 8'h00);
    tick();
    rdy = 1'b0;
    #1;
    chk("midwr_adr", o_adr, 16'h3000);
    chk("midwr_rw", o_rw, 1'b0);
    chk("midwr_data_out", o_dout, 8'hA5);
    wc = wcnt;
    reset_dut(1'b0, 16'hFFFE, 1);
    chk("midwr_no_write", wcnt, wc);
    chk("midwr_mem_kept", mem[16'h3000], 8'h11);

    // pc wrap FFFF->0000, then ea wrap FFFF+1 through the penalty cycle.
    run_instr(3'd4, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'hAD, 8'h34, 8'h12, 0);
    run_instr(3'd5, 1'b0, 8'h01, 8'h00, 1'b0, 8'h00, 8'hBD, 8'hFF, 8'hFF, 0);
    run_random(40);
    drain();

    // Instance B: fixed start PC, no page-cross penalty.
    reset_dut(1'b1, 16'h0000, 0);
    run_instr(3'd1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'hA9, 8'h42, 8'h00, 0);
    run_instr(3'd5, 1'b1, 8'h00, 8'h01, 1'b0, 8'h00, 8'hB9, 8'hFF, 8'h12, 0);
    run_instr(3'd2, 1'b0, 8'h00, 8'h00, 1'b1, 8'hC3, 8'h85, 8'h80, 8'h00, 2);
    run_instr(3'd5, 1'b0, 8'h01, 8'h00, 1'b1, 8'h9E, 8'h9D, 8'hFF, 8'h40, 0);
    run_random(80);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
